multicycle_control: RTL
=======================

# multicycle_control

Moore-style main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback for every instruction. It drives the datapath mux selects, write strobes and memory handshake. It generates the 3-bit `alu_op` consumed by the ALU decode stage directly downstream.

## Interface
- No parameters.
- `clk` in 1: core clock, all state on rising edge.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `opcode` in 7: IR[6:0]; stable from the cycle after `ir_write`.
- `funct3` in 3: IR[14:12].
- `alu_zero` in 1: ALU result == 0, combinational from the datapath.
- `mem_ready` in 1: memory completes the current `mem_req` this cycle.
- `alu_op` out 3: 000 add, 001 sub, 010 funct-decoded, 011 branch compare, 100 and.
- `alu_src_a` out 2: 00 PC, 01 old_pc, 10 rs1 reg, 11 alu_out reg.
- `alu_src_b` out 2: 00 rs2 reg, 01 imm, 10 const 4, 11 const 0xFFFF_FFFE.
- `result_src` out 2: 00 alu_out reg, 01 mem read data, 10 ALU result (comb), 11 imm.
- `imm_src` out 3: 000 I, 001 S, 010 B, 011 U, 100 J.
  - Decoded combinationally from `opcode` in every state.
  - Unknown opcode gives 000.
- `adr_src` out 1: 0 PC, 1 alu_out.
- `mem_req` out 1: memory request.
- `mem_write` out 1: request is a store.
- `pc_write` out 1: PC <= result.
- `ir_write` out 1: IR and old_pc <= read data and PC.
- `reg_write` out 1: rd <= result.
- `instr_retired` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal_instr` out 1: sticky; set on entry to TRAP.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR_ADD, JALR_MASK, JALR_LINK, LUI, TRAP.
- All outputs are decoded from the state, plus the `mem_ready`, `alu_zero`, `funct3` and `opcode` qualifiers noted below.
- Any output not listed for a state is 0.
- FETCH:
  - `mem_req`=1, `adr_src`=0.
  - ALU computes PC+4: A=00, B=10, `alu_op`=000, `result_src`=10.
  - `ir_write`=`pc_write`=`mem_ready`.
  - Go to DECODE when `mem_ready`; otherwise stay.
- DECODE:
  - ALU computes old_pc+imm into alu_out (A=01, B=01, op 000).
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR_ADD.
    - 0110111 → LUI.
    - 0010111 → ALUWB (AUIPC; alu_out already holds old_pc+imm).
    - 0001111 → FETCH with `instr_retired` (FENCE is a no-op).
    - anything else, including 1110011 → TRAP.
- MEMADR:
  - A=10, B=01, op 000.
  - Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD:
  - `mem_req`=1, `adr_src`=1.
  - Go to MEMWB on `mem_ready`.
- MEMWB:
  - `result_src`=01, `reg_write`=1, retire.
  - Next: FETCH.
- MEMWRITE:
  - `mem_req`=`mem_write`=1, `adr_src`=1.
  - On `mem_ready`: retire and go to FETCH.
- EXECR:
  - A=10, B=00, op 010.
  - Next: ALUWB.
- EXECI:
  - A=10, B=01.
  - op 010, except op 000 when `funct3`==000.
  - Reason: ADDI immediate bits must never select sub.
  - Next: ALUWB.
- ALUWB:
  - `result_src`=00, `reg_write`=1, retire.
  - Next: FETCH.
- BRANCH:
  - A=10, B=00, op 011, `result_src`=00 (target).
  - Taken condition:
    - `funct3` 000: `alu_zero`.
    - `funct3` 001, 100, 110: !`alu_zero`.
    - `funct3` 101, 111: `alu_zero`.
    - `funct3` 010, 011 → TRAP, no `pc_write`.
  - `pc_write`=taken; retire.
  - Next: FETCH.
- JAL:
  - `result_src`=00, `pc_write`=1.
  - ALU computes old_pc+4 (A=01, B=10, op 000) into alu_out.
  - Next: ALUWB.
- JALR_ADD:
  - A=10, B=01, op 000.
  - Next: JALR_MASK.
- JALR_MASK:
  - A=11, B=11, op 100, `result_src`=10, `pc_write`=1.
  - Next: JALR_LINK.
- JALR_LINK:
  - A=01, B=10, op 000, `result_src`=10, `reg_write`=1, retire.
  - Next: FETCH.
- LUI:
  - `result_src`=11, `reg_write`=1, retire.
  - Next: FETCH.
- TRAP:
  - Terminal; all strobes 0; `illegal_instr`=1.
  - Left only by reset.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state=FETCH, `illegal_instr`=0.
  - `mem_req`, `mem_write`, `pc_write`, `ir_write`, `reg_write` and `instr_retired` are forced 0 while `rst_n` is low.
  - Selects take their FETCH values.
- After `rst_n` deasserts, the first FETCH request appears in the first cycle.
- Reset during a memory wait abandons the request immediately; no strobe fires.
- CPI with zero-wait memory (`mem_ready` high in the same cycle as `mem_req`):
  - load 5, store 4, R/I 4, branch 3, JAL 4, JALR 5, LUI 3, AUIPC 3, FENCE 2.
- Each wait cycle adds 1 to a FETCH, MEMREAD or MEMWRITE stay.
- `mem_ready` is ignored outside those three states.
- While waiting, all strobes except `mem_req`/`mem_write` stay 0.
- `instr_retired` fires exactly once per completed instruction and never in TRAP.

## Test plan
- Reset, then R-type ADD (0110011) with zero-wait memory:
  - States go FETCH, DECODE, EXECR, ALUWB.
  - `alu_op` is 010 in EXECR.
  - `reg_write` and `instr_retired` are high only in cycle 4.
- Load with `mem_ready` low for 3 cycles in MEMREAD:
  - Total 8 cycles.
  - `reg_write` with `result_src`=01 occurs exactly once.
- ADDI whose imm[11:5]=0100000:
  - EXECI `alu_op`=000.
  - SRAI (`funct3`=101) gives `alu_op`=010.
- BNE with `alu_zero`=1 gives `pc_write`=0 in BRANCH; with `alu_zero`=0 gives `pc_write`=1.
- BGEU with `alu_zero`=1 gives `pc_write`=1.
- JALR: selects in order are (10,01,000), (11,11,100), (01,10,000).
  - `pc_write` is high in cycle 4.
  - `reg_write` is high in cycle 5.
- Opcode 1110011:
  - Goes to TRAP in cycle 3; `illegal_instr`=1 sticky with no strobes.
  - Asserting `rst_n` low clears it asynchronously.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore main control FSM for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       instr_retired,
  output logic       illegal_instr
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADR    = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXECR     = 4'd6;
  localparam logic [3:0] S_EXECI     = 4'd7;
  localparam logic [3:0] S_ALUWB     = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR_ADD  = 4'd11;
  localparam logic [3:0] S_JALR_MASK = 4'd12;
  localparam logic [3:0] S_JALR_LINK = 4'd13;
  localparam logic [3:0] S_LUI       = 4'd14;
  localparam logic [3:0] S_TRAP      = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       req_c, wr_c, pcw_c, irw_c, rw_c, ret_c;

  // Next state and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    alu_op     = 3'b000;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    req_c      = 1'b0;
    wr_c       = 1'b0;
    pcw_c      = 1'b0;
    irw_c      = 1'b0;
    rw_c       = 1'b0;
    ret_c      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        req_c      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw_c      = mem_ready;
        pcw_c      = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:    state_d = S_EXECR;
          OP_IMM:    state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR_ADD;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_ALUWB;
          OP_FENCE: begin
            state_d = S_FETCH;
            ret_c   = 1'b1;
          end
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_c   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        rw_c       = 1'b1;
        ret_c      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c   = 1'b1;
        wr_c    = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          ret_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 3'b010;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // ADDI imm[10] must not be read as the sub bit
        alu_op    = (funct3 == 3'b000) ? 3'b000 : 3'b010;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rw_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 3'b011;
        state_d   = S_FETCH;
        ret_c     = 1'b1;
        unique case (funct3)
          3'b000, 3'b101, 3'b111: pcw_c = alu_zero;
          3'b001, 3'b100, 3'b110: pcw_c = !alu_zero;
          default: begin
            ret_c   = 1'b0;
            state_d = S_TRAP;
          end
        endcase
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw_c     = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR_ADD: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JALR_MASK;
      end
      S_JALR_MASK: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b11;
        alu_op     = 3'b100;
        result_src = 2'b10;
        pcw_c      = 1'b1;
        state_d    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        rw_c       = 1'b1;
        ret_c      = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        result_src = 2'b11;
        rw_c       = 1'b1;
        ret_c      = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Immediate format decoded from opcode in every state
  always_comb begin
    unique case (opcode)
      OP_STORE:          imm_src = 3'b001;
      OP_BRANCH:         imm_src = 3'b010;
      OP_LUI, OP_AUIPC:  imm_src = 3'b011;
      OP_JAL:            imm_src = 3'b100;
      default:           imm_src = 3'b000;
    endcase
  end

  // Strobes held off while reset is asserted
  assign mem_req       = req_c & rst_n;
  assign mem_write     = wr_c  & rst_n;
  assign pc_write      = pcw_c & rst_n;
  assign ir_write      = irw_c & rst_n;
  assign reg_write     = rw_c  & rst_n;
  assign instr_retired = ret_c & rst_n;
  assign illegal_instr = illegal_q;

  // State and sticky trap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
